// File: rtl/nsdp_error_reporter.sv
// nsdp_error_reporter: AXI4-Lite status/error reporter with sticky first-error capture for NUM_CH checker channels
module nsdp_error_reporter #(
  parameter int NUM_CH = 2,
  parameter int ERR_W  = 15,
  parameter int DATA_W = 512
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        ch_status,
  input  logic [NUM_CH-1:0]        ch_eth_active,
  input  logic [NUM_CH-1:0]        ch_error_valid,
  input  logic [NUM_CH*ERR_W-1:0]  ch_error,
  input  logic [NUM_CH*DATA_W-1:0] ch_error_data,
  input  logic [NUM_CH*64-1:0]     ch_packets_rcvd,
  output logic                     irq,
  input  logic [31:0]              S_AXI_AWADDR,
  input  logic [2:0]               S_AXI_AWPROT,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [31:0]              S_AXI_ARADDR,
  input  logic [2:0]               S_AXI_ARPROT,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY
);
  localparam int NW = DATA_W / 32;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;
  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d, w_dec, r_dec;
  logic [31:0] rdata_q, rdata_d, r_val;
  logic [NUM_CH-1:0] sticky_q, irq_en_q, snap, clr;
  logic irq_q, w_fire, r_fire, sticky_wr, irq_en_wr;
  logic [ERR_W-1:0] err_q [NUM_CH];
  logic [DATA_W-1:0] data_q [NUM_CH];
  logic [31:0] cnt_q [NUM_CH];
  logic [31:0] shadow_q [NUM_CH];
  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WDATA, S_AXI_WSTRB,
                    S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  // Write address decode: OKAY for STICKY/IRQ_EN, SLVERR for other mapped registers
  always_comb begin
    w_dec = DECERR;
    if (S_AXI_AWADDR[31:8] == '0)
      case (S_AXI_AWADDR[7:2])
        6'h00, 6'h01, 6'h04: w_dec = SLVERR;
        6'h02, 6'h03:        w_dec = OKAY;
        default:             w_dec = DECERR;
      endcase
    for (int i = 0; i < NUM_CH; i++)
      if (S_AXI_AWADDR[31:12] == '0 && S_AXI_AWADDR[11:8] == 4'(i + 1))
        w_dec = (S_AXI_AWADDR[7:4] == 4'h0 ||
                 (S_AXI_AWADDR[7:6] == 2'b01 && int'(S_AXI_AWADDR[5:2]) < NW)) ? SLVERR : DECERR;
  end
  assign w_fire    = S_AXI_AWREADY;
  assign sticky_wr = w_fire && S_AXI_AWADDR[31:2] == 30'h2 && S_AXI_WSTRB[0];
  assign irq_en_wr = w_fire && S_AXI_AWADDR[31:2] == 30'h3 && S_AXI_WSTRB[0];
  assign clr       = {NUM_CH{sticky_wr}} & S_AXI_WDATA[NUM_CH-1:0];
  // Read address decode and data mux; a PKTS_H hit flags its channel for a shadow snapshot
  always_comb begin
    r_dec = DECERR;
    r_val = '0;
    snap  = '0;
    if (S_AXI_ARADDR[31:8] == '0) begin
      r_dec = OKAY;
      case (S_AXI_ARADDR[7:2])
        6'h00:   r_val = 32'(ch_status);
        6'h01:   r_val = 32'(ch_eth_active);
        6'h02:   r_val = 32'(sticky_q);
        6'h03:   r_val = 32'(irq_en_q);
        6'h04:   r_val = {16'd0, 8'(NW), 8'(NUM_CH)};
        default: r_dec = DECERR;
      endcase
    end
    for (int i = 0; i < NUM_CH; i++)
      if (S_AXI_ARADDR[31:12] == '0 && S_AXI_ARADDR[11:8] == 4'(i + 1)) begin
        r_dec = OKAY;
        case (S_AXI_ARADDR[7:2])
          6'h00: r_val = 32'(err_q[i]);
          6'h01: r_val = cnt_q[i];
          6'h02: begin
            r_val   = ch_packets_rcvd[i*64+32 +: 32];
            snap[i] = 1'b1;
          end
          6'h03: r_val = shadow_q[i];
          default: begin
            if (S_AXI_ARADDR[7:6] == 2'b01 && int'(S_AXI_ARADDR[5:2]) < NW)
              r_val = data_q[i][DATA_W-1-32*int'(S_AXI_ARADDR[5:2]) -: 32];
            else
              r_dec = DECERR;
          end
        endcase
      end
  end
  // Write channel FSM: accept AW and W together, then hold the response until BREADY
  always_comb begin
    wstate_d      = wstate_q;
    bresp_d       = bresp_q;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    if (wstate_q == W_IDLE) begin
      if (S_AXI_AWVALID && S_AXI_WVALID) begin
        S_AXI_AWREADY = 1'b1;
        S_AXI_WREADY  = 1'b1;
        bresp_d       = w_dec;
        wstate_d      = W_RESP;
      end
    end else if (S_AXI_BREADY) wstate_d = W_IDLE;
  end
  // Read channel FSM: latch data and response at the AR handshake, hold until RREADY
  always_comb begin
    rstate_d      = rstate_q;
    rresp_d       = rresp_q;
    rdata_d       = rdata_q;
    S_AXI_ARREADY = 1'b0;
    if (rstate_q == R_IDLE) begin
      if (S_AXI_ARVALID) begin
        S_AXI_ARREADY = 1'b1;
        rresp_d       = r_dec;
        rdata_d       = r_val;
        rstate_d      = R_DATA;
      end
    end else if (S_AXI_RREADY) rstate_d = R_IDLE;
  end
  assign r_fire       = S_AXI_ARREADY;
  assign S_AXI_BVALID = wstate_q == W_RESP;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rstate_q == R_DATA;
  assign S_AXI_RRESP  = rresp_q;
  assign S_AXI_RDATA  = rdata_q;
  assign irq          = irq_q;
  // AXI FSM state and response registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      bresp_q  <= OKAY;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      bresp_q  <= bresp_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end
  // Per-channel capture, saturating count, W1C (error wins a tie), shadows, IRQ_EN and irq
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sticky_q <= '0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        err_q[i]    <= '0;
        data_q[i]   <= '0;
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      if (irq_en_wr) irq_en_q <= S_AXI_WDATA[NUM_CH-1:0];
      irq_q <= |(sticky_q & irq_en_q);
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_error_valid[i] && (!sticky_q[i] || clr[i])) begin
          err_q[i]    <= ch_error[i*ERR_W +: ERR_W];
          data_q[i]   <= ch_error_data[i*DATA_W +: DATA_W];
          sticky_q[i] <= 1'b1;
          cnt_q[i]    <= 32'd1;
        end else if (ch_error_valid[i]) begin
          cnt_q[i] <= cnt_q[i] + {31'd0, ~&cnt_q[i]};
        end else if (clr[i]) begin
          sticky_q[i] <= 1'b0;
          cnt_q[i]    <= '0;
        end
        if (r_fire && snap[i]) shadow_q[i] <= ch_packets_rcvd[i*64 +: 32];
      end
    end
  end
endmodule

// File: tb/tb_nsdp_error_reporter.sv
// tb_nsdp_error_reporter: directed self-checking bench for nsdp_error_reporter
module tb_nsdp_error_reporter;
  localparam int NUM_CH = 2, ERR_W = 15, DATA_W = 512;
  logic clk, resetn, irq;
  logic [NUM_CH-1:0] ch_status, ch_eth_active, ch_error_valid;
  logic [NUM_CH*ERR_W-1:0] ch_error;
  logic [NUM_CH*DATA_W-1:0] ch_error_data;
  logic [NUM_CH*64-1:0] ch_packets_rcvd;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;
  int vec, miss;
  logic irq_hs;
  logic [31:0] d;
  logic [1:0] r;

  nsdp_error_reporter #(.NUM_CH(NUM_CH), .ERR_W(ERR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .resetn(resetn), .ch_status(ch_status), .ch_eth_active(ch_eth_active),
    .ch_error_valid(ch_error_valid), .ch_error(ch_error), .ch_error_data(ch_error_data),
    .ch_packets_rcvd(ch_packets_rcvd), .irq(irq),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s,
                    input logic [1:0] ev, output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    awaddr = a; wdata = dat; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    ch_error_valid = ev;
    n = 0;
    @(negedge clk);
    while (!awready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; ch_error_valid = '0;
    n = 0;
    @(negedge clk);
    irq_hs = irq;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    chk("wr_timeout", 32'(n < 20), 1);
    resp = bresp;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] dat, output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    chk("rd_timeout", 32'(n < 20), 1);
    dat = rdata; resp = rresp;
    @(posedge clk); #1;
  endtask

  task automatic rdchk(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    logic [31:0] od;
    logic [1:0] orr;
    rd(a, od, orr);
    chk($sformatf("rd_data@%h", a), od, ed);
    chk($sformatf("rd_resp@%h", a), 32'(orr), 32'(er));
  endtask

  task automatic wrchk(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s,
                       input logic [1:0] ev, input logic [1:0] er);
    logic [1:0] orr;
    wr(a, dat, s, ev, orr);
    chk($sformatf("wr_resp@%h", a), 32'(orr), 32'(er));
  endtask

  task automatic pulse(input logic [1:0] ev);
    @(posedge clk); #1;
    ch_error_valid = ev;
    @(posedge clk); #1;
    ch_error_valid = '0;
  endtask

  initial begin
    vec = 0; miss = 0;
    resetn = 1'b0;
    ch_status = 2'b10; ch_eth_active = 2'b01; ch_error_valid = '0;
    ch_error = '0; ch_error_data = '0; ch_packets_rcvd = '0;
    awaddr = '0; wdata = '0; wstrb = '0; awprot = '0; arprot = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_bresp", 32'(bresp), 0);
    chk("rst_rresp", 32'(rresp), 0);
    chk("rst_rdata", rdata, 0);
    rdchk(32'h10, 32'h0000_1002, 2'b00);
    rdchk(32'h300, 32'h0, 2'b11);
    rdchk(32'h00, 32'h2, 2'b00);
    rdchk(32'h04, 32'h1, 2'b00);
    rdchk(32'h08, 32'h0, 2'b00);
    rdchk(32'h14, 32'h0, 2'b11);
    rdchk(32'h1000, 32'h0, 2'b11);
    // first error on channel 1
    ch_error[ERR_W +: ERR_W] = 15'h1234;
    ch_error_data[1023:992] = 32'hDEAD_BEEF;
    ch_error_data[543:512] = 32'h0000_CAFE;
    pulse(2'b10);
    rdchk(32'h08, 32'h2, 2'b00);
    rdchk(32'h200, 32'h1234, 2'b00);
    rdchk(32'h240, 32'hDEAD_BEEF, 2'b00);
    rdchk(32'h27C, 32'h0000_CAFE, 2'b00);
    rdchk(32'h280, 32'h0, 2'b11);
    rdchk(32'h204, 32'h1, 2'b00);
    // later errors only count
    ch_error[ERR_W +: ERR_W] = 15'h0555;
    ch_error_data[1023:992] = 32'h0BAD_F00D;
    pulse(2'b10); pulse(2'b10); pulse(2'b10);
    rdchk(32'h200, 32'h1234, 2'b00);
    rdchk(32'h240, 32'hDEAD_BEEF, 2'b00);
    rdchk(32'h204, 32'h4, 2'b00);
    rdchk(32'h104, 32'h0, 2'b00);
    // clear, IRQ_EN with byte strobes, interrupt timing
    wrchk(32'h08, 32'h2, 4'hF, 2'b00, 2'b00);
    rdchk(32'h08, 32'h0, 2'b00);
    rdchk(32'h204, 32'h0, 2'b00);
    wrchk(32'h0C, 32'hFF, 4'h0, 2'b00, 2'b00);
    rdchk(32'h0C, 32'h0, 2'b00);
    wrchk(32'h0C, 32'hFF, 4'h1, 2'b00, 2'b00);
    rdchk(32'h0C, 32'h3, 2'b00);
    wrchk(32'h0C, 32'h2, 4'hF, 2'b00, 2'b00);
    chk("irq_idle", 32'(irq), 0);
    ch_error[ERR_W +: ERR_W] = 15'h0777;
    pulse(2'b10);
    @(negedge clk);
    chk("irq_same_cycle", 32'(irq), 0);
    @(negedge clk);
    chk("irq_rise", 32'(irq), 1);
    wrchk(32'h08, 32'h2, 4'hF, 2'b00, 2'b00);
    chk("irq_at_w1c", 32'(irq_hs), 1);
    chk("irq_fall", 32'(irq), 0);
    rdchk(32'h204, 32'h0, 2'b00);
    rdchk(32'h200, 32'h0777, 2'b00);
    // same-cycle W1C and error on channel 0
    ch_error[0 +: ERR_W] = 15'h0AAA;
    ch_error_data[511:480] = 32'h1111_1111;
    pulse(2'b01); pulse(2'b01);
    rdchk(32'h104, 32'h2, 2'b00);
    wrchk(32'h08, 32'h1, 4'h0, 2'b00, 2'b00);
    rdchk(32'h08, 32'h1, 2'b00);
    ch_error[0 +: ERR_W] = 15'h0BBB;
    ch_error_data[511:480] = 32'h2222_2222;
    wrchk(32'h08, 32'h1, 4'hF, 2'b01, 2'b00);
    rdchk(32'h08, 32'h1, 2'b00);
    rdchk(32'h100, 32'h0BBB, 2'b00);
    rdchk(32'h140, 32'h2222_2222, 2'b00);
    rdchk(32'h104, 32'h1, 2'b00);
    // coherent packet counter reads
    ch_packets_rcvd = {64'h0000_0003_0000_0007, 64'h0000_0001_FFFF_FFFF};
    rdchk(32'h10C, 32'h0, 2'b00);
    rdchk(32'h108, 32'h1, 2'b00);
    ch_packets_rcvd[63:0] = 64'h0000_0002_0000_0005;
    rdchk(32'h10C, 32'hFFFF_FFFF, 2'b00);
    rdchk(32'h20C, 32'h0, 2'b00);
    rdchk(32'h208, 32'h3, 2'b00);
    rdchk(32'h20C, 32'h7, 2'b00);
    // write responses
    wrchk(32'h00, 32'hFF, 4'hF, 2'b00, 2'b10);
    wrchk(32'h200, 32'hFF, 4'hF, 2'b00, 2'b10);
    wrchk(32'h300, 32'hFF, 4'hF, 2'b00, 2'b11);
    wrchk(32'h14, 32'hFF, 4'hF, 2'b00, 2'b11);
    rdchk(32'h200, 32'h0777, 2'b00);
    // B channel back-pressure
    @(posedge clk); #1;
    awaddr = 32'h04; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bhold_valid", 32'(bvalid), 1);
      chk("bhold_resp", 32'(bresp), 32'(2'b10));
    end
    bready = 1'b1;
    @(posedge clk); #1;
    chk("bhold_done", 32'(bvalid), 0);
    // R channel back-pressure
    @(posedge clk); #1;
    araddr = 32'h100; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rhold_valid", 32'(rvalid), 1);
      chk("rhold_data", rdata, 32'h0BBB);
      chk("rhold_resp", 32'(rresp), 0);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    chk("rhold_done", 32'(rvalid), 0);
    // reset in the middle of a read
    @(posedge clk); #1;
    araddr = 32'h10; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    chk("mid_rvalid", 32'(rvalid), 1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_async_rvalid", 32'(rvalid), 0);
    chk("rst_async_rdata", rdata, 0);
    rready = 1'b1;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_rvalid", 32'(rvalid), 0);
      chk("post_rst_bvalid", 32'(bvalid), 0);
    end
    rdchk(32'h08, 32'h0, 2'b00);
    rdchk(32'h0C, 32'h0, 2'b00);
    rdchk(32'h104, 32'h0, 2'b00);
    rdchk(32'h10C, 32'h0, 2'b00);
    chk("post_rst_irq", 32'(irq), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
